// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } loader_state_t;

    localparam int BYTE_W = 8;

    function automatic int bytesOf(input int width);
        return width / BYTE_W;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Word stream in, byte write port out; the loader is the slave side.
import imem_pkg::*;

interface imem_loader_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);

    logic                     s_valid;
    logic                     s_ready;
    logic [DATA_WIDTH-1:0]    s_data;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [BYTE_W-1:0]        mem_wdata;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

endinterface

// File: rtl/imem_loader.sv
// Serialises stream words into little-endian byte writes
// at consecutive instruction-memory addresses.
import imem_pkg::*;

module imem_loader #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH-1:0] word_count,
    imem_loader_if.slave             bus,
    output logic                     busy,
    output logic                     done,
    output logic                     wrapped
);

    localparam int BYTES = bytesOf(DATA_WIDTH);
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ONE = ADDRESS_WIDTH'(1);

    generate
        if (DATA_WIDTH % BYTE_W != 0) begin : gBadWidth
            $error("imem_loader: DATA_WIDTH must be a multiple of 8");
        end
    endgenerate

    loader_state_t state;
    loader_state_t nextState;

    logic [ADDRESS_WIDTH-1:0] addr;
    logic [ADDRESS_WIDTH-1:0] remaining;
    logic [DATA_WIDTH-1:0]    word;
    logic [IDX_W-1:0]         idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nextState = (word_count != '0) ? RECV : DONE;
                end
            end
            RECV: begin
                if (bus.s_valid) begin
                    nextState = WRITE;
                end
            end
            WRITE: begin
                if (idx == LAST_IDX) begin
                    nextState = (remaining == ONE) ? DONE : RECV;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
        endcase
    end

    // Datapath; a mid-word reset simply abandons the partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
            word      <= '0;
            idx       <= '0;
            wrapped   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= word_count;
                        wrapped   <= 1'b0;
                    end
                end
                RECV: begin
                    if (bus.s_valid) begin
                        word <= bus.s_data;
                        idx  <= '0;
                    end
                end
                WRITE: begin
                    addr <= addr + ONE;
                    idx  <= idx + 1'b1;
                    if (&addr) begin
                        wrapped <= 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        remaining <= remaining - ONE;
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

    assign bus.s_ready   = (state == RECV);
    assign bus.mem_we    = (state == WRITE);
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = word[BYTE_W*idx +: BYTE_W];
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed vector bench for imem_loader: byte order, timing,
// stalls, wrap, zero count, ignored start and mid-word reset.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic        wrapped;

    imem_loader_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) bus ();

    imem_loader #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .bus        (bus.slave),
        .busy       (busy),
        .done       (done),
        .wrapped    (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] base;
        logic [15:0] count;
        logic [31:0] w [3];
        int          stall;
        bit          ign;
        int          nWr;
        int          doneAt;
        bit          wrap;
        logic [15:0] firstA;
        logic [7:0]  firstD;
        logic [15:0] lastA;
        logic [7:0]  lastD;
    } vec_t;

    int passCnt = 0;
    int totalCnt = 0;

    logic [15:0] wA [$];
    logic [7:0]  wD [$];
    int          doneCyc;
    logic        busyAfter;
    logic        wrapAfter;
    int          stallReady;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        totalCnt++;
        if (act === exp) begin
            passCnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic runLoad(input logic [15:0] b, input logic [15:0] c,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input int stall,
                           input bit ign);
        logic [31:0] w [3];
        int k;
        int stallLeft;
        int cnt;
        w = '{w0, w1, w2};
        wA.delete();
        wD.delete();
        doneCyc = -1;
        stallReady = 0;
        k = 0;
        stallLeft = 0;
        cnt = 0;
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        word_count = c;
        @(posedge clk);
        while (doneCyc < 0 && cnt < 300) begin
            @(negedge clk);
            cnt++;
            start = 1'b0;
            base_addr = 16'h5A5A;
            word_count = 16'h0007;
            if (ign && cnt == 3) begin
                start = 1'b1;
                base_addr = 16'h8000;
                word_count = 16'h0001;
            end
            if (bus.mem_we) begin
                wA.push_back(bus.mem_addr);
                wD.push_back(bus.mem_wdata);
            end
            if (done) doneCyc = cnt;
            if (k < int'(c)) begin
                if (bus.s_ready && stallLeft > 0) begin
                    bus.s_valid = 1'b0;
                    stallLeft--;
                    stallReady++;
                end else begin
                    bus.s_valid = 1'b1;
                    bus.s_data = w[k];
                    if (bus.s_ready) begin
                        k++;
                        stallLeft = stall;
                    end
                end
            end else begin
                bus.s_valid = 1'b0;
            end
        end
        bus.s_valid = 1'b0;
        if (doneCyc < 0) begin
            check("done_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
        busyAfter = busy;
        repeat (3) @(negedge clk);
        wrapAfter = wrapped;
    endtask

    vec_t vecs [6];

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;

        vecs[0] = '{"single", 16'h0010, 16'd1,
                    '{32'hDEADBEEF, 32'h0, 32'h0}, 0, 1'b0, 4, 6, 1'b0,
                    16'h0010, 8'hEF, 16'h0013, 8'hDE};
        vecs[1] = '{"b2b", 16'h0000, 16'd3,
                    '{32'h00000013, 32'h00100093, 32'hFFF08093},
                    0, 1'b0, 12, 16, 1'b0,
                    16'h0000, 8'h13, 16'h000B, 8'hFF};
        vecs[2] = '{"stall", 16'h0040, 16'd2,
                    '{32'h01020304, 32'hA0B0C0D0, 32'h0}, 7, 1'b0, 8,
                    18, 1'b0, 16'h0040, 8'h04, 16'h0047, 8'hA0};
        vecs[3] = '{"wrap", 16'hFFFE, 16'd1,
                    '{32'h11223344, 32'h0, 32'h0}, 0, 1'b0, 4, 6, 1'b1,
                    16'hFFFE, 8'h44, 16'h0001, 8'h11};
        vecs[4] = '{"ignstart", 16'h0020, 16'd1,
                    '{32'hCAFEF00D, 32'h0, 32'h0}, 0, 1'b1, 4, 6, 1'b0,
                    16'h0020, 8'h0D, 16'h0023, 8'hCA};
        vecs[5] = '{"zero", 16'h0300, 16'd0,
                    '{32'h0, 32'h0, 32'h0}, 0, 1'b0, 0, 1, 1'b0,
                    16'h0, 8'h0, 16'h0, 8'h0};

        repeat (2) @(negedge clk);
        check("reset_outputs",
              {27'd0, busy, done, wrapped, bus.s_ready, bus.mem_we}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            runLoad(vecs[v].base, vecs[v].count, vecs[v].w[0],
                    vecs[v].w[1], vecs[v].w[2], vecs[v].stall, vecs[v].ign);
            check({vecs[v].name, "_nwr"}, wA.size(), vecs[v].nWr);
            for (int i = 0; i < wA.size() && i < vecs[v].nWr; i++) begin
                logic [15:0] ea;
                logic [31:0] ew;
                ea = vecs[v].base + 16'(i);
                ew = vecs[v].w[i / 4] >> (8 * (i % 4));
                check($sformatf("%s_addr%0d", vecs[v].name, i), wA[i], ea);
                check($sformatf("%s_data%0d", vecs[v].name, i), wD[i],
                      ew[7:0]);
            end
            if (wA.size() == vecs[v].nWr && vecs[v].nWr > 0) begin
                check({vecs[v].name, "_first"}, {wA[0], wD[0]},
                      {vecs[v].firstA, vecs[v].firstD});
                check({vecs[v].name, "_last"},
                      {wA[wA.size()-1], wD[wD.size()-1]},
                      {vecs[v].lastA, vecs[v].lastD});
            end
            check({vecs[v].name, "_donecyc"}, doneCyc, vecs[v].doneAt);
            check({vecs[v].name, "_busyafter"}, busyAfter, 1'b0);
            check({vecs[v].name, "_wrapped"}, wrapAfter, vecs[v].wrap);
            if (vecs[v].stall > 0) begin
                check({vecs[v].name, "_readyhold"}, stallReady,
                      vecs[v].stall);
            end
        end

        // Mid-word reset after the second byte, then a clean reload.
        begin
            int seen;
            int guard;
            seen = 0;
            guard = 0;
            @(negedge clk);
            start = 1'b1;
            base_addr = 16'h0100;
            word_count = 16'd2;
            bus.s_valid = 1'b1;
            bus.s_data = 32'hA1B2C3D4;
            while (seen < 2 && guard < 50) begin
                @(negedge clk);
                guard++;
                start = 1'b0;
                if (bus.mem_we) seen++;
            end
            check("rstmid_reach", seen, 2);
            bus.s_valid = 1'b0;
            @(posedge clk);
            #1 rst = 1'b1;
            #1;
            check("rstmid_outputs",
                  {27'd0, busy, done, wrapped, bus.s_ready, bus.mem_we},
                  32'd0);
            @(negedge clk);
            check("rstmid_held", {31'd0, bus.mem_we}, 32'd0);
            rst = 1'b0;
            @(negedge clk);
            check("rstmid_idle", {31'd0, busy}, 32'd0);
        end
        runLoad(16'h0200, 16'd1, 32'h55667788, 32'h0, 32'h0, 0, 1'b0);
        check("reload_nwr", wA.size(), 4);
        if (wA.size() == 4) begin
            check("reload_w0", {wA[0], wD[0]}, {16'h0200, 8'h88});
            check("reload_w1", {wA[1], wD[1]}, {16'h0201, 8'h77});
            check("reload_w2", {wA[2], wD[2]}, {16'h0202, 8'h66});
            check("reload_w3", {wA[3], wD[3]}, {16'h0203, 8'h55});
        end
        check("reload_donecyc", doneCyc, 6);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
